// File: rtl/btn_player_pkg.sv
// Shared types and screen-bound defaults for the player controller.
// The renderer imports the same bounds.
package btn_player_pkg;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_STEP = 1'b1
  } state_e;

  localparam int X_MAX_DEF     = 639;
  localparam int Y_MAX_DEF     = 479;
  localparam int X_INIT_DEF    = 320;
  localparam int Y_INIT_DEF    = 240;
  localparam int STEP_DEF      = 4;
  localparam int DEB_TICKS_DEF = 2;
  localparam int PW_DEF        = 10;

endpackage

// File: rtl/btn_player_ctrl_debounce.sv
// One button: 2-FF synchroniser, tick-sampled shift register,
// and a level that only flips once every sample agrees.
module btn_debounce
  import btn_player_pkg::*;
#(
  parameter int DEB_TICKS = DEB_TICKS_DEF
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  input  logic tick_i,
  output logic deb_o
);

  logic                 s1_q;
  logic                 s2_q;
  logic [DEB_TICKS-1:0] sh_q;
  logic [DEB_TICKS-1:0] sh_d;
  logic [DEB_TICKS-1:0] sh_shift;
  logic                 deb_q;
  logic                 deb_d;

  if (DEB_TICKS > 1) begin : g_multi
    assign sh_shift = {sh_q[DEB_TICKS-2:0], s2_q};
  end else begin : g_one
    assign sh_shift = s2_q;
  end

  // Bring the raw asynchronous button into the clock domain
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= btn_i;
      s2_q <= s1_q;
    end
  end

  // Shift on tick; debounced level changes only on unanimous history
  always_comb begin
    sh_d  = sh_q;
    deb_d = deb_q;
    if (tick_i) begin
      sh_d = sh_shift;
      if (&sh_shift) begin
        deb_d = 1'b1;
      end else if (~|sh_shift) begin
        deb_d = 1'b0;
      end
    end
  end

  // History and debounced level registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sh_q  <= '0;
      deb_q <= 1'b0;
    end else begin
      sh_q  <= sh_d;
      deb_q <= deb_d;
    end
  end

  assign deb_o = deb_q;

endmodule

// File: rtl/btn_player_ctrl.sv
// Player movement: edge-detects the slow movement clock, debounces
// the direction buttons and steps a clamped on-screen position.
module btn_player_ctrl
  import btn_player_pkg::*;
#(
  parameter int X_MAX     = X_MAX_DEF,
  parameter int Y_MAX     = Y_MAX_DEF,
  parameter int X_INIT    = X_INIT_DEF,
  parameter int Y_INIT    = Y_INIT_DEF,
  parameter int STEP      = STEP_DEF,
  parameter int DEB_TICKS = DEB_TICKS_DEF,
  parameter int PW        = PW_DEF
) (
  input  logic          Clk_In,
  input  logic          rst,
  input  logic          btnClk,
  input  logic          btnU,
  input  logic          btnD,
  input  logic          btnL,
  input  logic          btnR,
  output logic [PW-1:0] posX,
  output logic [PW-1:0] posY,
  output logic          moved
);

  localparam logic [PW:0] XLIM = (PW+1)'(X_MAX);
  localparam logic [PW:0] YLIM = (PW+1)'(Y_MAX);
  localparam logic [PW:0] STW  = (PW+1)'(STEP);

  logic          ck_s1_q;
  logic          ck_s2_q;
  logic [1:0]    fill_q;
  logic          prev_q;
  logic          tick;
  logic          tick_acc;
  state_e        state_q;
  state_e        state_d;
  logic [PW-1:0] posx_q;
  logic [PW-1:0] posx_d;
  logic [PW-1:0] posy_q;
  logic [PW-1:0] posy_d;
  logic          moved_q;
  logic          moved_d;
  logic          deb_u;
  logic          deb_d;
  logic          deb_l;
  logic          deb_r;

  // One axis step: inc-only adds, dec-only subtracts, both/neither hold
  function automatic logic [PW-1:0] step_axis(
    input logic [PW-1:0] p,
    input logic          inc,
    input logic          dec,
    input logic [PW:0]   lim
  );
    logic [PW:0] w;
    w = {1'b0, p};
    if (inc && !dec) begin
      w = w + STW;
      if (w > lim) w = lim;
    end else if (dec && !inc) begin
      if (w < STW) w = '0;
      else         w = w - STW;
    end
    return w[PW-1:0];
  endfunction

  // Synchronise btnClk; prev holds 1 until the chain has filled so a
  // btnClk already high at reset release never looks like an edge
  always_ff @(posedge Clk_In) begin
    if (rst) begin
      ck_s1_q <= 1'b0;
      ck_s2_q <= 1'b0;
      fill_q  <= 2'b00;
      prev_q  <= 1'b1;
    end else begin
      ck_s1_q <= btnClk;
      ck_s2_q <= ck_s1_q;
      fill_q  <= {fill_q[0], 1'b1};
      if (fill_q[1]) prev_q <= ck_s2_q;
    end
  end

  assign tick     = ck_s2_q & ~prev_q;
  assign tick_acc = tick & (state_q == S_IDLE);

  btn_debounce #(.DEB_TICKS(DEB_TICKS)) u_deb_u (
    .clk_i(Clk_In), .rst_i(rst), .btn_i(btnU),
    .tick_i(tick_acc), .deb_o(deb_u)
  );
  btn_debounce #(.DEB_TICKS(DEB_TICKS)) u_deb_d (
    .clk_i(Clk_In), .rst_i(rst), .btn_i(btnD),
    .tick_i(tick_acc), .deb_o(deb_d)
  );
  btn_debounce #(.DEB_TICKS(DEB_TICKS)) u_deb_l (
    .clk_i(Clk_In), .rst_i(rst), .btn_i(btnL),
    .tick_i(tick_acc), .deb_o(deb_l)
  );
  btn_debounce #(.DEB_TICKS(DEB_TICKS)) u_deb_r (
    .clk_i(Clk_In), .rst_i(rst), .btn_i(btnR),
    .tick_i(tick_acc), .deb_o(deb_r)
  );

  // Next state: wait for a tick, then one step cycle using fresh levels
  always_comb begin
    state_d = state_q;
    posx_d  = posx_q;
    posy_d  = posy_q;
    moved_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (tick) state_d = S_STEP;
      end
      S_STEP: begin
        posx_d  = step_axis(posx_q, deb_r, deb_l, XLIM);
        posy_d  = step_axis(posy_q, deb_d, deb_u, YLIM);
        moved_d = (posx_d != posx_q) || (posy_d != posy_q);
        state_d = S_IDLE;
      end
    endcase
  end

  // State, position and move-pulse registers
  always_ff @(posedge Clk_In) begin
    if (rst) begin
      state_q <= S_IDLE;
      posx_q  <= PW'(X_INIT);
      posy_q  <= PW'(Y_INIT);
      moved_q <= 1'b0;
    end else begin
      state_q <= state_d;
      posx_q  <= posx_d;
      posy_q  <= posy_d;
      moved_q <= moved_d;
    end
  end

  assign posX  = posx_q;
  assign posY  = posy_q;
  assign moved = moved_q;

endmodule
